mid_bram_rd_sched: RTL

- Read-side scheduler for the 4-bank row buffer that sits between convolution stages.
- Counts rows completed by the write side. Once three consecutive rows are resident, it sweeps them out in parallel, one column per cycle: it drives rd_addr and the per-bank read enables, and reports which bank holds the top row.
- It emits a data-valid aligned with the BRAM outputs, so the downstream 3x3 window/MAC stage can mux qa/qb/qc by row_sel and consume one column per de_out.

---
 rtl/mid_bram_rd_sched.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mid_bram_rd_sched.sv
// Read-side scheduler for the 4-bank inter-stage row buffer: once three rows are resident
// it sweeps them one column per cycle and emits a data-valid aligned with the BRAM q outputs.
module mid_bram_rd_sched #(
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int RD_LAT  = 1,
    parameter int GAP_CYC = 2
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        frame_start,
    input  logic        row_done,
    output logic [10:0] rd_addr,
    output logic        in0_rden,
    output logic        in1_rden,
    output logic        in2_rden,
    output logic        in3_rden,
    output logic [1:0]  row_sel,
    output logic        de_out,
    output logic [10:0] col_out,
    output logic [10:0] row_out,
    output logic        busy,
    output logic        frame_done,
    output logic        ovf_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_READ,
        S_GAP,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [10:0]       rows_wr_q, rows_wr_d;
    logic [10:0]       out_row_q, out_row_d;
    logic [10:0]       rd_addr_q, rd_addr_d;
    logic [3:0]        gap_q, gap_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [10:0]       col_q [RD_LAT];
    logic [10:0]       col_d [RD_LAT];
    logic [10:0]       row_q [RD_LAT];
    logic [10:0]       row_d [RD_LAT];

    logic       rd_act;
    logic       ready3;
    logic       ahead4;
    logic       last_col;
    logic [1:0] skip_bank;
    logic [3:0] rden;

    assign rd_act    = (state_q == S_READ);
    assign ready3    = {1'b0, rows_wr_q} >= ({1'b0, out_row_q} + 12'd3);
    assign ahead4    = {1'b0, rows_wr_q} >= ({1'b0, out_row_q} + 12'd4);
    assign last_col  = (rd_addr_q == 11'(IMG_W - 1));
    assign skip_bank = out_row_q[1:0] + 2'd3;

    // Valid/column/row delay line; data stages load only behind a valid so they hold when idle.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = rd_act;
        col_d[0] = rd_act ? rd_addr_q : col_q[0];
        row_d[0] = rd_act ? out_row_q : row_q[0];
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            col_d[i] = vld_q[i-1] ? col_q[i-1] : col_q[i];
            row_d[i] = vld_q[i-1] ? row_q[i-1] : row_q[i];
        end
        if (frame_start) begin
            vld_d = '0;
        end
    end

    always_comb begin
        // NOTE: every signal gets its default before the case so no path can infer a latch.
        state_d   = state_q;
        rows_wr_d = rows_wr_q;
        out_row_d = out_row_q;
        rd_addr_d = rd_addr_q;
        gap_d     = gap_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;

        if (state_q != S_IDLE && row_done && rows_wr_q != 11'(IMG_H)) begin
            rows_wr_d = rows_wr_q + 11'd1;
        end
        // A row landing while four are unread means the top bank was overwritten mid-sweep.
        if (row_done && ahead4 &&
            (state_q == S_WAIT || state_q == S_READ || state_q == S_GAP)) begin
            ovf_d = 1'b1;
        end

        case (state_q)
            S_WAIT: begin
                if (ready3) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (last_col) begin
                    rd_addr_d = '0;
                    out_row_d = out_row_q + 11'd1;
                    gap_d     = '0;
                    if (out_row_q + 11'd1 == 11'(IMG_H - 2)) begin
                        state_d = S_DRAIN;
                    end else if (GAP_CYC == 0) begin
                        state_d = ahead4 ? S_READ : S_WAIT;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    rd_addr_d = rd_addr_q + 11'd1;
                end
            end
            S_GAP: begin
                if (int'(gap_q) == GAP_CYC - 1) begin
                    state_d = ready3 ? S_READ : S_WAIT;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            S_DRAIN: begin
                if (vld_d == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: ;
        endcase

        if (frame_start) begin
            state_d   = S_WAIT;
            rows_wr_d = '0;
            out_row_d = '0;
            rd_addr_d = '0;
            gap_d     = '0;
            ovf_d     = 1'b0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            rows_wr_q <= '0;
            out_row_q <= '0;
            rd_addr_q <= '0;
            gap_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            vld_q     <= '0;
            // NOTE: the delay-line arrays are reset too, so col_out/row_out read 0 out of reset.
            for (int i = 0; i < RD_LAT; i++) begin
                col_q[i] <= '0;
                row_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q   <= state_d;
            rows_wr_q <= rows_wr_d;
            out_row_q <= out_row_d;
            rd_addr_q <= rd_addr_d;
            gap_q     <= gap_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            vld_q     <= vld_d;
            col_q     <= col_d;
            row_q     <= row_d;
        end
    end

    always_comb begin
        rden = '0;
        if (rd_act) begin
            rden            = 4'b1111;
            rden[skip_bank] = 1'b0;
        end
    end

    assign rd_addr    = rd_addr_q;
    assign in0_rden   = rden[0];
    assign in1_rden   = rden[1];
    assign in2_rden   = rden[2];
    assign in3_rden   = rden[3];
    assign row_sel    = out_row_q[1:0];
    assign de_out     = vld_q[RD_LAT-1];
    assign col_out    = col_q[RD_LAT-1];
    assign row_out    = row_q[RD_LAT-1];
    assign busy       = (state_q != S_IDLE);
    assign frame_done = done_q;
    assign ovf_err    = ovf_q;

endmodule
